vram_dma_ctrl: RTL and testbench

VRAM_DMA_CTRL -- requirements
Module: vram_dma_ctrl

---
 rtl/vram_dma_ctrl_pkg.sv | 16 +
 rtl/vram_dma_ctrl_regfile.sv | 48 ++++
 rtl/vram_dma_ctrl.sv | 118 +++++++++++
 tb/tb_vram_dma_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_dma_ctrl_pkg.sv
// rtl/vram_dma_ctrl_pkg.sv - shared FSM encoding and DMAC register map
package vram_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } dma_state_t;

  localparam logic [3:0] REG_BASE  = 4'h4;
  localparam logic [3:0] REG_COUNT = 4'h5;
  localparam logic [3:0] REG_MODE  = 4'h8;
  localparam int         MODE_EN_BIT = 2;

endpackage

// File: rtl/vram_dma_ctrl_regfile.sv
// rtl/vram_dma_ctrl_regfile.sv - CPU-visible base/count/mode registers with byte flip-flop
module dmac_regfile
  import vram_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] DEF_BASE  = 16'hF300,
  parameter logic [13:0] DEF_COUNT = 14'd2999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmac_we,
  input  logic [3:0]  adr,
  input  logic [7:0]  data,
  output logic [15:0] base,
  output logic [13:0] count,
  output logic        enable
);

  logic byte_ff;

  // Mode bits riding in the top of the count high byte are discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      base    <= DEF_BASE;
      count   <= DEF_COUNT;
      enable  <= 1'b1;
      byte_ff <= 1'b0;
    end else if (dmac_we) begin
      case (adr)
        REG_BASE: begin
          if (byte_ff) base[15:8] <= data;
          else         base[7:0]  <= data;
          byte_ff <= ~byte_ff;
        end
        REG_COUNT: begin
          if (byte_ff) count[13:8] <= data[5:0];
          else         count[7:0]  <= data;
          byte_ff <= ~byte_ff;
        end
        REG_MODE: begin
          enable  <= data[MODE_EN_BIT];
          byte_ff <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_dma_ctrl.sv
// rtl/vram_dma_ctrl.sv - video row DMA: bus request FSM, address/count tracking, row buffer writes
module vram_dma_ctrl
  import vram_dma_ctrl_pkg::*;
#(
  parameter int          ROW_BYTES = 120,
  parameter logic [15:0] DEF_BASE  = 16'hF300,
  parameter logic [13:0] DEF_COUNT = 14'd2999
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmac_we,
  input  logic [3:0]  adr,
  input  logic [7:0]  data,
  input  logic        row_req,
  input  logic        frame_start,
  output logic        busreq,
  input  logic        busack,
  output logic [16:0] ram_adr,
  output logic        row_we,
  output logic [6:0]  row_adr,
  output logic        tc,
  output logic        overrun
);

  localparam logic [6:0] LAST_IDX = 7'(ROW_BYTES - 1);

  dma_state_t  state, state_nxt;
  logic [15:0] base, cur_adr;
  logic [13:0] count, remaining;
  logic        enable, pending, reload_pend;
  logic        do_reload, start, last_byte;

  dmac_regfile #(
    .DEF_BASE  (DEF_BASE),
    .DEF_COUNT (DEF_COUNT)
  ) u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .dmac_we (dmac_we),
    .adr     (adr),
    .data    (data),
    .base    (base),
    .count   (count),
    .enable  (enable)
  );

  assign ram_adr = {1'b0, cur_adr};

  // A reload seen in IDLE takes effect before the start decision of that same cycle.
  always_comb begin
    do_reload = (state == IDLE) && (frame_start || reload_pend);
    start     = (row_req || (pending && !do_reload)) && enable && (do_reload || !tc);
    last_byte = (row_adr == LAST_IDX) || (remaining == 14'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busreq    = 1'b0;
    row_we    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        busreq = 1'b1;
        if (busack) state_nxt = XFER;
      end
      XFER: begin
        busreq = 1'b1;
        row_we = 1'b1;
        if (last_byte) state_nxt = REL;
      end
      REL:     if (!busack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_adr     <= DEF_BASE;
      remaining   <= DEF_COUNT;
      tc          <= 1'b0;
      overrun     <= 1'b0;
      pending     <= 1'b0;
      reload_pend <= 1'b0;
      row_adr     <= 7'd0;
    end else begin
      if (do_reload) begin
        cur_adr     <= base;
        remaining   <= count;
        tc          <= 1'b0;
        overrun     <= 1'b0;
        reload_pend <= 1'b0;
      end else if (frame_start && state != IDLE) begin
        reload_pend <= 1'b1;
      end

      if (state == XFER) begin
        cur_adr <= cur_adr + 16'd1;
        if (remaining == 14'd0) tc <= 1'b1;
        else                    remaining <= remaining - 14'd1;
        row_adr <= last_byte ? 7'd0 : row_adr + 7'd1;
      end

      // One request can queue behind the active burst; a second one is lost.
      if (state == IDLE) begin
        if (do_reload || start) pending <= 1'b0;
      end else if (row_req && enable && !tc) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_dma_ctrl.sv
// tb/tb_vram_dma_ctrl.sv - self-checking bench for vram_dma_ctrl
module tb_vram_dma_ctrl;

  localparam int ROW_BYTES = 120;

  logic        CLK = 1'b0, RST = 1'b1, dmac_we = 1'b0, row_req = 1'b0, frame_start = 1'b0, busack = 1'b0;
  logic [3:0]  adr = 4'h0;
  logic [7:0]  data = 8'h00;
  logic        busreq, row_we, tc, overrun;
  logic [16:0] ram_adr;
  logic [6:0]  row_adr;

  vram_dma_ctrl #(.ROW_BYTES(ROW_BYTES), .DEF_BASE(16'hF300), .DEF_COUNT(14'd2999)) dut (
    .CLK(CLK), .RST(RST), .dmac_we(dmac_we), .adr(adr), .data(data),
    .row_req(row_req), .frame_start(frame_start), .busreq(busreq), .busack(busack),
    .ram_adr(ram_adr), .row_we(row_we), .row_adr(row_adr), .tc(tc), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int ack_lat = 2, ack_cnt = 0;
  int cap_adr[$];
  int cap_row[$];
  logic prev_we = 1'b0, busreq_after_last = 1'b1;

  logic [15:0] m_base;
  logic [13:0] m_count;
  bit          m_en, m_ff, m_tc;
  int          m_cur, m_rem;

  always @(posedge CLK) begin
    #2;
    if (busreq) begin
      if (ack_cnt + 1 >= ack_lat) busack = 1'b1;
      else ack_cnt++;
    end else begin
      busack  = 1'b0;
      ack_cnt = 0;
    end
  end

  always @(negedge CLK) begin
    if (row_we) begin
      cap_adr.push_back(ram_adr[16] ? -1 : int'(ram_adr));
      cap_row.push_back(int'(row_adr));
    end
    if (prev_we && !row_we) busreq_after_last = busreq;
    prev_we = row_we;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_base = 16'hF300; m_count = 14'd2999; m_en = 1; m_ff = 0;
    m_cur = 'hF300; m_rem = 2999; m_tc = 0;
  endtask

  task automatic model_reload();
    m_cur = int'(m_base); m_rem = int'(m_count); m_tc = 0;
  endtask

  function automatic int model_nb();
    if (!m_en || m_tc) return 0;
    return (m_rem + 1 < ROW_BYTES) ? m_rem + 1 : ROW_BYTES;
  endfunction

  task automatic model_advance(input int nb);
    m_cur = (m_cur + nb) % 65536;
    if (nb > 0) begin
      if (nb == m_rem + 1) begin m_tc = 1; m_rem = 0; end
      else m_rem -= nb;
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    dmac_we = 1'b1; adr = a; data = d;
    tick();
    dmac_we = 1'b0;
    case (a)
      4'h4: begin if (m_ff) m_base[15:8] = d; else m_base[7:0] = d; m_ff = !m_ff; end
      4'h5: begin if (m_ff) m_count[13:8] = d[5:0]; else m_count[7:0] = d; m_ff = !m_ff; end
      4'h8: begin m_en = d[2]; m_ff = 0; end
      default: ;
    endcase
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_reload();
  endtask

  task automatic pulse_row();
    row_req = 1'b1;
    tick();
    row_req = 1'b0;
  endtask

  task automatic clear_cap();
    cap_adr.delete();
    cap_row.delete();
    busreq_after_last = 1'b1;
  endtask

  function automatic int first_cap();
    return (cap_adr.size() > 0) ? cap_adr[0] : -1;
  endfunction

  function automatic int last_cap();
    return (cap_adr.size() > 0) ? cap_adr[cap_adr.size() - 1] : -1;
  endfunction

  task automatic wait_idle(input bit expect_burst, input string nm);
    int  run = 0;
    bit  seen = 0, done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (busreq) begin seen = 1; run = 0; end
      else if (!busack) run++;
      else run = 0;
      if (expect_burst ? (seen && run >= 3) : (i >= 8)) done = 1;
      else tick();
    end
    if (!done) check({nm, " idle timeout"}, 0, 1);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    for (int i = 0; i < 500 && cap_adr.size() < n; i++) tick();
    check({nm, " reached byte"}, cap_adr.size() >= n, 1);
  endtask

  task automatic check_seq(input string nm, input int st, input int nb);
    int mism = 0;
    check({nm, " bytes"}, cap_adr.size(), nb);
    for (int i = 0; i < nb && i < cap_adr.size(); i++)
      if (cap_adr[i] != (st + i) % 65536 || cap_row[i] != i % ROW_BYTES) mism++;
    check({nm, " mismatching bytes"}, mism, 0);
  endtask

  task automatic do_row(input string nm, input bit with_frame);
    int nb, st;
    if (with_frame) model_reload();
    nb = model_nb();
    st = m_cur;
    clear_cap();
    row_req = 1'b1; frame_start = with_frame;
    tick();
    row_req = 1'b0; frame_start = 1'b0;
    wait_idle(nb > 0, nm);
    check_seq(nm, st, nb);
    model_advance(nb);
    check({nm, " tc"}, tc, m_tc);
    check({nm, " overrun"}, overrun, 0);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [13:0] cnt;
    int          rows;
    int          lat;
    int          exp_first;
    int          exp_bytes;
    bit          exp_tc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int st, tot, first;
    vecs[0] = '{16'hF300, 14'd2999, 1, 2, 'hF300, 120, 0};
    vecs[1] = '{16'h4000, 14'd119,  2, 1, 'h4000, 120, 1};
    vecs[2] = '{16'hFFC0, 14'd2999, 1, 3, 'hFFC0, 120, 0};
    vecs[3] = '{16'h1234, 14'd5,    1, 0, 'h1234, 6,   1};
    vecs[4] = '{16'h0010, 14'd239,  3, 4, 'h0010, 240, 1};
    vecs[5] = '{16'h8000, 14'd120,  2, 2, 'h8000, 121, 1};

    model_reset();
    repeat (3) tick();
    RST = 1'b0;
    check("reset busreq", busreq, 0);
    check("reset row_we", row_we, 0);
    check("reset row_adr", row_adr, 0);
    check("reset tc", tc, 0);
    check("reset overrun", overrun, 0);
    check("reset ram_adr", ram_adr, 17'h0F300);

    ack_lat = 2;
    do_row("r041", 0);
    check("r041 last adr", last_cap(), 'hF377);
    check("r041 busreq after last", busreq_after_last, 0);

    pulse_frame();
    clear_cap();
    st = m_cur;
    pulse_row();
    wait_bytes(50, "r045");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle(1, "r045");
    check_seq("r045", st, 120);
    check("r045 last adr", last_cap(), 'hF377);
    model_advance(120);
    model_reload();
    do_row("r045b", 0);
    check("r045b first adr", first_cap(), 'hF300);

    clear_cap();
    st = m_cur;
    pulse_row();
    wait_bytes(10, "r043");
    repeat (3) begin
      pulse_row();
      tick();
    end
    wait_idle(1, "r043");
    check_seq("r043", st, 2 * ROW_BYTES);
    model_advance(ROW_BYTES);
    model_advance(ROW_BYTES);
    check("r043 overrun", overrun, 1);
    pulse_frame();
    check("frame clears overrun", overrun, 0);

    clear_cap();
    st = m_cur;
    pulse_row();
    wait_bytes(20, "r033");
    cpu_write(4'h8, 8'h00);
    wait_idle(1, "r033");
    check_seq("r033", st, ROW_BYTES);
    model_advance(ROW_BYTES);
    do_row("r033 disabled", 0);
    cpu_write(4'h8, 8'h04);

    cpu_write(4'h4, 8'h00);
    cpu_write(4'h4, 8'h50);
    do_row("r035", 1);
    check("r035 first adr", first_cap(), 'h5000);

    clear_cap();
    pulse_row();
    wait_bytes(30, "r046");
    RST = 1'b1;
    tick();
    check("r046 busreq", busreq, 0);
    check("r046 row_we", row_we, 0);
    check("r046 row_adr", row_adr, 0);
    check("r046 tc", tc, 0);
    check("r046 overrun", overrun, 0);
    check("r046 ram_adr", ram_adr, 17'h0F300);
    RST = 1'b0;
    model_reset();
    tick();
    do_row("r046 after", 0);

    for (int v = 0; v < 6; v++) begin
      ack_lat = vecs[v].lat;
      cpu_write(4'h8, 8'h04);
      cpu_write(4'h4, vecs[v].base[7:0]);
      cpu_write(4'h4, vecs[v].base[15:8]);
      cpu_write(4'h5, vecs[v].cnt[7:0]);
      cpu_write(4'h5, {2'b11, vecs[v].cnt[13:8]});
      pulse_frame();
      tot = 0;
      first = -1;
      for (int r = 0; r < vecs[v].rows; r++) begin
        do_row($sformatf("vec%0d row%0d", v, r), 0);
        if (r == 0) first = first_cap();
        tot += cap_adr.size();
      end
      check($sformatf("vec%0d first adr", v), first, vecs[v].exp_first);
      check($sformatf("vec%0d total bytes", v), tot, vecs[v].exp_bytes);
      check($sformatf("vec%0d tc", v), tc, vecs[v].exp_tc);
    end

    for (int k = 0; k < 8; k++) begin
      logic [15:0] b;
      logic [13:0] c;
      logic [7:0]  mode;
      b = 16'($urandom);
      c = 14'($urandom_range(0, 400));
      mode = 8'($urandom) & 8'hFB;
      if ($urandom_range(0, 4) != 0) mode = mode | 8'h04;
      ack_lat = $urandom_range(0, 4);
      cpu_write(4'h8, mode);
      cpu_write(4'h4, b[7:0]);
      cpu_write(4'h4, b[15:8]);
      cpu_write(4'h5, c[7:0]);
      cpu_write(4'h5, {2'($urandom), c[13:8]});
      pulse_frame();
      for (int r = 0; r < $urandom_range(1, 4); r++)
        do_row($sformatf("rand%0d row%0d", k, r), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
